ypbpr_to_rgb: RTL
=================

YPBPR_TO_RGB -- requirements
Module: ypbpr_to_rgb

Interface
REQ-001 Parameter WIDTH, default 8, is the bit width of every colour component in and out.
REQ-002 Parameter LATENCY is fixed at 3; it documents the pipeline depth and is not user-tunable.
REQ-003 Clocking and reset SHALL be: one clock; reset is asynchronous and active-low.
REQ-004 clk  in  1  pixel-domain clock; all logic on its rising edge.
REQ-005 reset_n  in  1  asynchronous active-low reset.
REQ-006 ena  in  1  1 = convert YPbPr->RGB, 0 = passthrough; sampled with the data.
REQ-007 y_in  in  WIDTH  luma, unsigned.
REQ-008 pb_in, pr_in  in  WIDTH each  chroma, offset-binary, zero at 2^(WIDTH-1).
REQ-009 hs_in, vs_in, hb_in, vb_in, cs_in, pixel_in  in  1 each  sync, blank and pixel strobes.
REQ-010 red_out, green_out, blue_out  out  WIDTH each  registered RGB result.
REQ-011 hs_out, vs_out, hb_out, vb_out, cs_out, pixel_out  out  1 each  strobes delayed to match the data.

Function
REQ-012 Stage 1 SHALL register Y zero-extended and Pb/Pr as signed (WIDTH+1)-bit values: pb_s = pb_in - 2^(WIDTH-1), pr_s = pr_in - 2^(WIDTH-1).
REQ-013 Stage 2 SHALL register the products Y*256, 359*pr_s, 88*pb_s, 183*pr_s and 454*pb_s in signed WIDTH+11-bit accumulators, with no truncation.
REQ-014 Stage 3 SHALL register the three channel results:
- R = (Y*256 + 359*pr_s + 128) >>> 8
- G = (Y*256 - 88*pb_s - 183*pr_s + 128) >>> 8
- B = (Y*256 + 454*pb_s + 128) >>> 8
REQ-015 Each channel result SHALL be clamped: below 0 -> 0; above 2^WIDTH-1 -> 2^WIDTH-1; otherwise the value unchanged.
REQ-016 Passthrough (ena=0) SHALL map red_out=pr_in, green_out=y_in and blue_out=pb_in unmodified, with no offset removal and no clamp.
REQ-017 Data-to-output latency SHALL be exactly 3 clk cycles in both modes.
REQ-018 ena SHALL be pipelined with the data, so a mode change mid-stream affects only pixels sampled after it, and there is no glitch or mixed-mode pixel.
REQ-019 Every strobe input SHALL reach its output after exactly 3 cycles, aligned with its pixel, in both modes.
REQ-020 The pipeline SHALL advance every cycle; there is no stall or back-pressure.
REQ-021 Converting mode SHALL be the numerical inverse of the team's RGB->YPbPr encoder to within +/-2 LSB per channel for in-gamut input (WIDTH=8).

Reset
REQ-022 While reset_n=0, all pipeline registers and all outputs SHALL be 0, including the RGB outputs and all strobes.
REQ-023 Reset asserted mid-frame SHALL clear outputs asynchronously, with no wait for a clk edge.
REQ-024 After reset_n rises, outputs SHALL stay 0 for the first 2 edges; the 3rd edge presents the first sampled pixel.

Structure
REQ-025 The coefficients (359, 88, 183, 454), the rounding constant 128, the shift of 8 and LATENCY SHALL live in a shared package ypbpr_pkg.
REQ-026 One sub-module, ypbpr_round_clamp, SHALL implement the round, arithmetic shift and saturate step; it is instantiated three times, once per channel, each with WIDTH and the sum as input.

Verification
REQ-027 Neutral grey: WIDTH=8, ena=1, Y=128, Pb=Pr=128 -> RGB=(128,128,128) exactly 3 cycles later; Y=200 neutral -> (200,200,200).
REQ-028 Clamp high/low: Y=255, Pr=255, Pb=128 -> R=255; Y=0, Pr=0, Pb=128 -> R=0.
REQ-029 Passthrough: ena=0, Y=0x12, Pb=0x34, Pr=0x56 -> (R,G,B)=(0x56,0x12,0x34) after 3 cycles.
REQ-030 Alignment: a 1-cycle pulse on each strobe together with a marked pixel -> each strobe output high in the same cycle as that pixel's RGB; toggle ena every cycle -> each pixel processed in its own mode.
REQ-031 Round trip: the team's RGB->YPbPr encoder feeding this block, sweeping all 8-bit primaries and greys -> every channel within +/-2 LSB of the original.
REQ-032 Reset: assert reset_n=0 mid-stream -> all outputs 0 immediately; release it -> first valid pixel at the 3rd clk edge.

Source files
------------

// File: rtl/ypbpr_pkg.sv
// Shared constants for the YPbPr -> RGB colour-space converter.
// Coefficients are BT.601 inverse-matrix terms scaled by 2^SHIFT.
package ypbpr_pkg;

  localparam int LATENCY = 3;
  localparam int SHIFT   = 8;
  localparam int RND     = 128;
  localparam int C_R_PR  = 359;
  localparam int C_G_PB  = 88;
  localparam int C_G_PR  = 183;
  localparam int C_B_PB  = 454;
  localparam int N_STB   = 6;

endpackage

// File: rtl/ypbpr_to_rgb_if.sv
// Pixel bus for the YPbPr -> RGB converter: input pixel, mode and strobes
// in, registered RGB and delayed strobes out.
interface ypbpr_to_rgb_if #(
  parameter int WIDTH = 8
);

  logic             ena;
  logic [WIDTH-1:0] y_in;
  logic [WIDTH-1:0] pb_in;
  logic [WIDTH-1:0] pr_in;
  logic             hs_in, vs_in, hb_in, vb_in, cs_in, pixel_in;
  logic [WIDTH-1:0] red_out;
  logic [WIDTH-1:0] green_out;
  logic [WIDTH-1:0] blue_out;
  logic             hs_out, vs_out, hb_out, vb_out, cs_out, pixel_out;

  modport master (
    output ena, y_in, pb_in, pr_in, hs_in, vs_in, hb_in, vb_in, cs_in, pixel_in,
    input  red_out, green_out, blue_out, hs_out, vs_out, hb_out, vb_out, cs_out, pixel_out
  );

  modport slave (
    input  ena, y_in, pb_in, pr_in, hs_in, vs_in, hb_in, vb_in, cs_in, pixel_in,
    output red_out, green_out, blue_out, hs_out, vs_out, hb_out, vb_out, cs_out, pixel_out
  );

endinterface

// File: rtl/ypbpr_round_clamp.sv
// Round, arithmetic shift and saturate one scaled channel sum to an
// unsigned WIDTH-bit component.
module ypbpr_round_clamp
  import ypbpr_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SUM_W = WIDTH + 12
) (
  input  logic signed [SUM_W-1:0] i_sum,
  output logic        [WIDTH-1:0] o_pix
);

  localparam logic signed [SUM_W-1:0] K_RND = SUM_W'(RND);
  localparam logic signed [SUM_W-1:0] K_MAX = SUM_W'((1 << WIDTH) - 1);

  logic signed [SUM_W-1:0] w_rounded;
  logic signed [SUM_W-1:0] w_shift;
  logic        [WIDTH-1:0] w_pix;

  assign w_rounded = i_sum + K_RND;
  assign w_shift   = w_rounded >>> SHIFT;

  // Saturate the shifted value into the unsigned output range.
  always_comb begin
    w_pix = '0;
    if (w_shift[SUM_W-1]) begin
      w_pix = '0;
    end else if (w_shift > K_MAX) begin
      w_pix = {WIDTH{1'b1}};
    end else begin
      w_pix = w_shift[WIDTH-1:0];
    end
  end

  assign o_pix = w_pix;

endmodule

// File: rtl/ypbpr_to_rgb.sv
// Three-stage YPbPr -> RGB converter with passthrough mode; mode and
// sync/blank strobes travel alongside the data so every pixel stays aligned.
module ypbpr_to_rgb
  import ypbpr_pkg::*;
#(
  parameter  int WIDTH   = 8,
  localparam int LAT     = LATENCY
) (
  input  logic            clk,
  input  logic            reset_n,
  ypbpr_to_rgb_if.slave   bus
);

  localparam int ACC_W = WIDTH + 11;
  localparam int SUM_W = WIDTH + 12;
  localparam logic signed [WIDTH:0]   K_OFS  = (WIDTH+1)'(1) << (WIDTH - 1);
  localparam logic signed [ACC_W-1:0] K_R_PR = ACC_W'(C_R_PR);
  localparam logic signed [ACC_W-1:0] K_G_PB = ACC_W'(C_G_PB);
  localparam logic signed [ACC_W-1:0] K_G_PR = ACC_W'(C_G_PR);
  localparam logic signed [ACC_W-1:0] K_B_PB = ACC_W'(C_B_PB);

  logic                    r1_ena, r2_ena;
  logic        [WIDTH-1:0] r1_y;
  logic signed [WIDTH:0]   r1_pb_s, r1_pr_s;
  logic        [WIDTH-1:0] r1_pb_raw, r1_pr_raw, r2_pb_raw, r2_pr_raw;
  logic signed [ACC_W-1:0] r2_y256, r2_r_pr, r2_g_pb, r2_g_pr, r2_b_pb;
  logic        [WIDTH-1:0] r_red, r_green, r_blue;
  logic        [N_STB-1:0] r_stb [LAT];

  logic signed [WIDTH:0]   w_pb_s, w_pr_s;
  logic signed [SUM_W-1:0] w_sum_r, w_sum_g, w_sum_b;
  logic        [WIDTH-1:0] w_r, w_g, w_b;
  logic        [N_STB-1:0] w_stb_in;

  assign w_pb_s   = $signed({1'b0, bus.pb_in}) - K_OFS;
  assign w_pr_s   = $signed({1'b0, bus.pr_in}) - K_OFS;
  assign w_stb_in = {bus.hs_in, bus.vs_in, bus.hb_in, bus.vb_in, bus.cs_in, bus.pixel_in};

  // Stage 1: capture luma, offset-removed chroma, raw chroma and mode.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r1_ena    <= 1'b0;
      r1_y      <= '0;
      r1_pb_s   <= '0;
      r1_pr_s   <= '0;
      r1_pb_raw <= '0;
      r1_pr_raw <= '0;
    end else begin
      r1_ena    <= bus.ena;
      r1_y      <= bus.y_in;
      r1_pb_s   <= w_pb_s;
      r1_pr_s   <= w_pr_s;
      r1_pb_raw <= bus.pb_in;
      r1_pr_raw <= bus.pr_in;
    end
  end

  // Stage 2: full-precision coefficient products.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r2_ena    <= 1'b0;
      r2_y256   <= '0;
      r2_r_pr   <= '0;
      r2_g_pb   <= '0;
      r2_g_pr   <= '0;
      r2_b_pb   <= '0;
      r2_pb_raw <= '0;
      r2_pr_raw <= '0;
    end else begin
      r2_ena    <= r1_ena;
      r2_y256   <= $signed({{(ACC_W-WIDTH-SHIFT){1'b0}}, r1_y, {SHIFT{1'b0}}});
      r2_r_pr   <= ACC_W'(r1_pr_s) * K_R_PR;
      r2_g_pb   <= ACC_W'(r1_pb_s) * K_G_PB;
      r2_g_pr   <= ACC_W'(r1_pr_s) * K_G_PR;
      r2_b_pb   <= ACC_W'(r1_pb_s) * K_B_PB;
      r2_pb_raw <= r1_pb_raw;
      r2_pr_raw <= r1_pr_raw;
    end
  end

  assign w_sum_r = SUM_W'(r2_y256) + SUM_W'(r2_r_pr);
  assign w_sum_g = SUM_W'(r2_y256) - SUM_W'(r2_g_pb) - SUM_W'(r2_g_pr);
  assign w_sum_b = SUM_W'(r2_y256) + SUM_W'(r2_b_pb);

  ypbpr_round_clamp #(.WIDTH(WIDTH), .SUM_W(SUM_W)) u_rc_r (.i_sum(w_sum_r), .o_pix(w_r));
  ypbpr_round_clamp #(.WIDTH(WIDTH), .SUM_W(SUM_W)) u_rc_g (.i_sum(w_sum_g), .o_pix(w_g));
  ypbpr_round_clamp #(.WIDTH(WIDTH), .SUM_W(SUM_W)) u_rc_b (.i_sum(w_sum_b), .o_pix(w_b));

  // Stage 3: select converted or passthrough pixel; luma is recovered from the Y*256 term.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_red   <= '0;
      r_green <= '0;
      r_blue  <= '0;
    end else if (r2_ena) begin
      r_red   <= w_r;
      r_green <= w_g;
      r_blue  <= w_b;
    end else begin
      r_red   <= r2_pr_raw;
      r_green <= r2_y256[SHIFT +: WIDTH];
      r_blue  <= r2_pb_raw;
    end
  end

  // Strobe delay line matching the data pipeline depth.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < LAT; i++) begin
        r_stb[i] <= '0;
      end
    end else begin
      r_stb[0] <= w_stb_in;
      for (int i = 1; i < LAT; i++) begin
        r_stb[i] <= r_stb[i-1];
      end
    end
  end

  assign bus.red_out   = r_red;
  assign bus.green_out = r_green;
  assign bus.blue_out  = r_blue;
  assign {bus.hs_out, bus.vs_out, bus.hb_out, bus.vb_out, bus.cs_out, bus.pixel_out} = r_stb[LAT-1];

endmodule
